led_flash_ctrl: RTL
===================

Name: led_flash_ctrl

Overview:
- Downstream consumer of the free-running 32-bit clock counter.
- Derives a slow update tick from a selectable counter bit and drives an LED bank with one of four flashing patterns: off, blink, chase, binary count.
- Sits between the counter and the board LED pins; it is the only block writing the LEDs.

Parameters:
- LED_W, 8, number of LED outputs (2..32).
- TAP_BASE, 20, counter bit index used when i_speed=0; TAP_BASE+7 must be <= 31.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  reset, synchronous, active-high.
- i_counter  input  32  free-running count from the upstream counter.
- i_mode  input  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT.
- i_speed  input  3  tap select; tap bit index = TAP_BASE + i_speed (higher value gives a slower pattern).
- i_enable  input  1  high advances the pattern; low freezes it.
- o_led  output  LED_W  registered LED drive.
- o_tick  output  1  registered one-cycle pulse, high on each pattern advance.

Behaviour:
Reset and synchronisation
- One clock. Reset is synchronous and active-high: i_reset sampled high at a rising i_clk edge resets the block.
- Reset values: o_led=0, o_tick=0, r_mode=OFF, r_bit_q=0, r_speed_q=0.
- Reset mid-pattern takes effect at the next edge and overrides every other event.

Tick generation
- sel = i_counter[TAP_BASE+i_speed].
- r_bit_q <= sel every cycle. r_speed_q <= i_speed every cycle.
- tick_c = sel & ~r_bit_q & (i_speed == r_speed_q). A speed change suppresses the tick for that one cycle, so there are no spurious edges.
- Counter wrap (0xFFFFFFFF->0) gives a falling tap bit and no tick.
- Edge tracking continues regardless of i_enable.

Mode tracking and pattern update
- r_mode <= i_mode every cycle.
- load_c = (i_mode != r_mode).
- Priority at each edge: reset > load > advance > hold.
- Load (applies next cycle, independent of i_enable or tick):
  - OFF: 0
  - BLINK: all ones
  - CHASE: LED_W'b1
  - COUNT: 0
- Advance when tick_c & i_enable & ~load_c:
  - OFF: stays 0.
  - BLINK: o_led <= ~o_led.
  - CHASE: rotate left by 1; MSB wraps to bit 0.
  - COUNT: o_led <= o_led + 1, modulo 2^LED_W; all ones wraps to 0.
- o_tick <= tick_c & i_enable & ~load_c. It is high in the same cycle the new o_led value appears.

Latency and rate
- Latency is one cycle from the tap-bit rise at the input to the o_led/o_tick update.
- Tick period is 2^(TAP_BASE+i_speed+1) clocks for a counter incrementing every cycle.

Decomposition:
- Package led_flash_pkg holds:
  - mode constants MODE_OFF=2'd0, MODE_BLINK=2'd1, MODE_CHASE=2'd2, MODE_COUNT=2'd3;
  - COUNTER_W=32;
  - SPEED_W=3.
- Sub-module led_tick_gen contains the tap mux, r_bit_q, r_speed_q and the tick_c output.
- The top level holds the mode register and the pattern state machine.

Test Plan:
Bench settings: TAP_BASE=0, LED_W=4, i_counter incrementing by 1 each clock, i_enable=1 unless stated.
- Reset: hold i_reset 3 cycles while the counter runs, with mode=2 -> o_led=0000 and o_tick=0 throughout. One cycle after release -> load gives o_led=0001.
- Chase: mode=2, speed=0 (tick every 2 clocks) -> o_led steps 0001, 0010, 0100, 1000, 0001 (wrap), with one o_tick pulse per step.
- Count: mode=3, speed=1 (tick every 4 clocks), 17 ticks -> o_led reaches 1111 after 15 ticks, 0000 at tick 16, 0001 at tick 17.
- Blink with enable: mode=1 -> o_led=1111 after load, then 0000, 1111 per tick. Drop i_enable for 10 clocks -> o_led frozen, o_tick stays 0. Re-enable -> toggling resumes on the next tap rise.
- Collisions:
  - Change i_mode 3->2 in the cycle tick_c is true -> o_led=0001 (load wins), no o_tick.
  - Change i_speed when the new tap bit=1 and r_bit_q=0 -> no tick that cycle.
- Reset mid-operation: assert i_reset for 1 cycle while mode=3 and o_led=0101 -> o_led=0000 next edge. After release -> mode reloads, and count restarts from 0000 on subsequent ticks.

Source files
------------

// File: rtl/led_flash_pkg.sv
// led_flash_pkg: shared widths and pattern-mode encoding for the LED flasher.
package led_flash_pkg;
  localparam int COUNTER_W = 32;
  localparam int SPEED_W = 3;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: rising-edge detector on a selectable counter tap bit.
module led_tick_gen
  import led_flash_pkg::*;
#(
  parameter int TAP_BASE = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [COUNTER_W-1:0] i_counter,
  input  logic [SPEED_W-1:0]   i_speed,
  output logic                 o_tick
);
  logic [4:0]         tap;
  logic               sel;
  logic               r_bit_q;
  logic [SPEED_W-1:0] r_speed_q;
  // A speed change compares against a different bit, so that cycle's edge is not trusted.
  always_comb begin
    tap = 5'(TAP_BASE) + 5'(i_speed);
    sel = i_counter[tap];
    o_tick = sel & ~r_bit_q & (i_speed == r_speed_q);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bit_q <= 1'b0;
      r_speed_q <= '0;
    end else begin
      r_bit_q <= sel;
      r_speed_q <= i_speed;
    end
  end
endmodule

// File: rtl/led_flash_ctrl.sv
// led_flash_ctrl: drives an LED bank with off/blink/chase/count patterns paced by a counter tap.
module led_flash_ctrl
  import led_flash_pkg::*;
#(
  parameter int LED_W = 8,
  parameter int TAP_BASE = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [COUNTER_W-1:0] i_counter,
  input  logic [1:0]           i_mode,
  input  logic [SPEED_W-1:0]   i_speed,
  input  logic                 i_enable,
  output logic [LED_W-1:0]     o_led,
  output logic                 o_tick
);
  localparam logic [LED_W-1:0] ONE = LED_W'(1);
  logic             tick_c, load_c, adv_c;
  logic [LED_W-1:0] load_val, adv_val;
  mode_e            r_mode;
  led_tick_gen #(.TAP_BASE(TAP_BASE)) u_tick (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_counter(i_counter),
    .i_speed  (i_speed),
    .o_tick   (tick_c)
  );
  // A mode change reloads the pattern and swallows any coincident advance.
  always_comb begin
    load_c = i_mode != r_mode;
    adv_c = tick_c & i_enable & ~load_c;
    load_val = i_mode == MODE_BLINK ? '1 : i_mode == MODE_CHASE ? ONE : '0;
    adv_val = r_mode == MODE_BLINK ? ~o_led :
              r_mode == MODE_CHASE ? {o_led[LED_W-2:0], o_led[LED_W-1]} :
              r_mode == MODE_COUNT ? o_led + ONE : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_led <= '0;
      o_tick <= 1'b0;
      r_mode <= MODE_OFF;
    end else begin
      r_mode <= mode_e'(i_mode);
      o_tick <= adv_c;
      o_led <= load_c ? load_val : adv_c ? adv_val : o_led;
    end
  end
endmodule
